// File: rtl/data_mem_sized_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : data_mem_sized_if
// Brief   : Request/response bus between the MEM stage and data_mem_sized.
// Revision: 1.0 - initial release
// ============================================================================
interface data_mem_sized_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_sized.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : data_mem_sized
// Brief   : Big-endian byte-addressed data memory, sized/extended access with
//           wait states. Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_sized #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  wire             clk,
  input  wire             rst_n,
  data_mem_sized_if.slave bus
);
  localparam int                c_IDX_W    = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] c_DEPTH    = ADDR_W'(DEPTH_BYTES);
  localparam logic [3:0]        c_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic [7:0]        mem_q [DEPTH_BYTES];

  logic              w_idle;
  logic              w_resp_edge;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_uns;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [ADDR_W-1:0] eff_addr;
  logic              misalign;
  logic [c_IDX_W-3:0] word_idx;
  logic [1:0]        lane;
  logic [1:0]        li;
  logic [7:0]        rd_b [4];
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;
  logic [3:0]        be;
  logic [7:0]        wb [4];
  logic              err_d;
  logic [31:0]       rdata_d;
  logic              commit_d;

  // With zero wait states the response is produced on the accept edge itself,
  // so the live bus fields are used in IDLE and the latched copy afterwards.
  assign w_idle      = (state_q == S_IDLE);
  assign w_resp_edge = (w_idle && bus.req_valid && (WAIT_CYCLES == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_comb begin
    sel_we    = w_idle ? bus.req_we       : we_q;
    sel_size  = w_idle ? bus.req_size     : size_q;
    sel_uns   = w_idle ? bus.req_unsigned : uns_q;
    sel_addr  = w_idle ? bus.req_addr     : addr_q;
    sel_wdata = w_idle ? bus.req_wdata    : wdata_q;

    eff_addr = sel_addr;
    misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = ((sel_size == 2'b01) && sel_addr[0]) ||
               ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
`else
    if (sel_size == 2'b01)      eff_addr[0]   = 1'b0;
    else if (sel_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
    // Accepted accesses are naturally aligned and DEPTH is a multiple of 4,
    // so checking the first byte covers every addressed byte.
    err_d    = (sel_size == 2'b11) || misalign || (eff_addr >= c_DEPTH);
    word_idx = eff_addr[c_IDX_W-1:2];
    lane     = eff_addr[1:0];

    li = 2'd0;
    for (int i = 0; i < 4; i++) begin
      li       = 2'(i);
      rd_b[i]  = mem_q[{word_idx, li}];
      case (sel_size)
        2'b00: begin
          be[i] = (lane == li);
          wb[i] = sel_wdata[7:0];
        end
        2'b01: begin
          be[i] = (lane[1] == li[1]);
          wb[i] = li[0] ? sel_wdata[7:0] : sel_wdata[15:8];
        end
        default: begin
          be[i] = 1'b1;
          wb[i] = sel_wdata[8*(3-i) +: 8];
        end
      endcase
    end

    rd_half = lane[1] ? {rd_b[2], rd_b[3]} : {rd_b[0], rd_b[1]};
    case (sel_size)
      2'b00:   ld_data = {{24{~sel_uns & rd_b[lane][7]}}, rd_b[lane]};
      2'b01:   ld_data = {{16{~sel_uns & rd_half[15]}}, rd_half};
      default: ld_data = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
    endcase

    rdata_d  = (sel_we || err_d) ? 32'd0 : ld_data;
    commit_d = w_resp_edge && sel_we && !err_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit_d && be[i]) mem_q[{word_idx, 2'(i)}] <= wb[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (w_resp_edge) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rdata_d;
        rsp_err_q   <= err_d;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= c_CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_sized.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_sized
// Brief   : Directed and model-checked bench for data_mem_sized, four instances
//           with WAIT_CYCLES 1, 3, 0, 5. Honours DMEM_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_sized;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid    [4];
  logic        req_we       [4];
  logic [1:0]  req_size     [4];
  logic        req_unsigned [4];
  logic [31:0] req_addr     [4];
  logic [31:0] req_wdata    [4];
  logic        req_ready    [4];
  logic        rsp_valid    [4];
  logic [31:0] rsp_rdata    [4];
  logic        rsp_err      [4];

  logic [7:0]  mdl [4][1024];
  int          n_checks = 0;
  int          n_fail   = 0;

  genvar gk;
  for (gk = 0; gk < 4; gk++) begin : g_dut
    localparam int W = (gk == 0) ? 1 : (gk == 1) ? 3 : (gk == 2) ? 0 : 5;
    data_mem_sized_if #(.ADDR_W(32)) bus ();
    assign bus.req_valid    = req_valid[gk];
    assign bus.req_we       = req_we[gk];
    assign bus.req_size     = req_size[gk];
    assign bus.req_unsigned = req_unsigned[gk];
    assign bus.req_addr     = req_addr[gk];
    assign bus.req_wdata    = req_wdata[gk];
    assign req_ready[gk]    = bus.req_ready;
    assign rsp_valid[gk]    = bus.rsp_valid;
    assign rsp_rdata[gk]    = bus.rsp_rdata;
    assign rsp_err[gk]      = bus.rsp_err;
    data_mem_sized #(.ADDR_W(32), .DEPTH_BYTES(1024), .WAIT_CYCLES(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 0;
      default: return 5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) check("ready_timeout", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic xact(input int k, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int n;
    wait_ready(k);
    req_we[k] = we; req_size[k] = sz; req_unsigned[k] = uns;
    req_addr[k] = a; req_wdata[k] = wd; req_valid[k] = 1'b1;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[k] && n < 40);
    check("latency", 32'(n), 32'(wait_of(k) + 1));
    rd = rsp_rdata[k];
    er = rsp_err[k];
    @(negedge clk);
    check("pulse_one", 32'(rsp_valid[k]), 32'd0);
    check("rdata_hold", rsp_rdata[k], rd);
  endtask

  task automatic do_ld(input int k, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] exp_rd, input logic exp_er, input string tag);
    logic [31:0] rd;
    logic        er;
    xact(k, 1'b0, sz, uns, a, 32'd0, rd, er);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask

  task automatic do_st(input int k, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_er, input string tag);
    logic [31:0] rd;
    logic        er;
    xact(k, 1'b1, sz, 1'b0, a, wd, rd, er);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask

  // Reference: byte array, big-endian, lowest address holds the most significant byte.
  task automatic model_xact(input int k, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int          nb;
    logic [31:0] ea;
    logic [31:0] v;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea = a;
    er = (sz == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % nb) != 0) er = 1'b1;
`else
    ea = a - (a % nb);
`endif
    if (ea + nb > 1024) er = 1'b1;
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mdl[k][ea + i] = wd[8*(nb-1-i) +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mdl[k][ea + i]);
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    logic [6:0]  rv;
    logic [6:0]  rr;
    logic [31:0] rd, erd;
    logic        er, eer, we, uns;
    logic [1:0]  sz;
    logic [31:0] a, v;

    for (int k = 0; k < 4; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'b00;
      req_unsigned[k] = 1'b0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready[0]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_err", 32'(rsp_err[0]), 32'd0);
    rst_n = 1'b1;

    // Reset during the wait of a store aborts it.
    do_st(1, 2'b10, 32'h10, 32'hA5A5_5A5A, 1'b0, "t1_prefill");
    wait_ready(1);
    req_we[1] = 1'b1; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h10; req_wdata[1] = 32'hDEAD_BEEF; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n  = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid[1]) pulses++;
    end
    check("t1_ready_in_rst", 32'(req_ready[1]), 32'd1);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) pulses++;
    end
    check("t1_no_rsp", 32'(pulses), 32'd0);
    do_ld(1, 2'b10, 1'b0, 32'h10, 32'hA5A5_5A5A, 1'b0, "t1_lw");

    // Latency and throughput with WAIT_CYCLES=3, req_valid held high.
    wait_ready(1);
    req_we[1] = 1'b0; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h10; req_wdata[1] = 32'd0; req_valid[1] = 1'b1;
    rv = '0;
    rr = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      rv[c-1] = rsp_valid[1];
      rr[c-1] = req_ready[1];
    end
    req_valid[1] = 1'b0;
    check("t4_rsp_vec", 32'(rv), 32'(7'b0001000));
    check("t4_ready_vec", 32'(rr), 32'(7'b0010000));
    check("t4_rdata", rsp_rdata[1], 32'hA5A5_5A5A);
    wait_ready(1);

    // Big-endian sized access on the WAIT_CYCLES=1 instance.
    do_st(0, 2'b10, 32'h20, 32'h1122_3344, 1'b0, "t2_sw");
    do_ld(0, 2'b00, 1'b0, 32'h20, 32'h0000_0011, 1'b0, "t2_lb20");
    do_ld(0, 2'b00, 1'b0, 32'h23, 32'h0000_0044, 1'b0, "t2_lb23");
    do_ld(0, 2'b01, 1'b0, 32'h22, 32'h0000_3344, 1'b0, "t2_lh22");
    do_ld(0, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0, "t2_lw20");
    do_st(0, 2'b00, 32'h21, 32'h1234_5680, 1'b0, "t3_sb");
    do_ld(0, 2'b10, 1'b0, 32'h20, 32'h1180_3344, 1'b0, "t3_lw");
    do_ld(0, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF80, 1'b0, "t3_lb");
    do_ld(0, 2'b00, 1'b1, 32'h21, 32'h0000_0080, 1'b0, "t3_lbu");
    do_st(0, 2'b10, 32'h24, 32'h0000_0000, 1'b0, "t3_sw0");
    do_st(0, 2'b01, 32'h24, 32'h7777_BEEF, 1'b0, "t3_sh");
    do_ld(0, 2'b10, 1'b0, 32'h24, 32'hBEEF_0000, 1'b0, "t3_lw24");
    do_ld(0, 2'b01, 1'b0, 32'h24, 32'hFFFF_BEEF, 1'b0, "t3_lh");
    do_ld(0, 2'b01, 1'b1, 32'h24, 32'h0000_BEEF, 1'b0, "t3_lhu");

    // Error and alignment handling.
    do_st(0, 2'b10, 32'h3FC, 32'hCAFE_F00D, 1'b0, "t5_sw3fc");
    do_st(0, 2'b10, 32'h0, 32'h0102_0304, 1'b0, "t5_sw0");
`ifdef DMEM_ALIGN_CHECK_EN
    do_ld(0, 2'b10, 1'b0, 32'h3FE, 32'h0000_0000, 1'b1, "t5_lw3fe");
    do_ld(0, 2'b01, 1'b0, 32'h21, 32'h0000_0000, 1'b1, "t5_lh21");
`else
    do_ld(0, 2'b10, 1'b0, 32'h3FE, 32'hCAFE_F00D, 1'b0, "t5_lw3fe");
    do_ld(0, 2'b01, 1'b0, 32'h21, 32'h0000_1180, 1'b0, "t5_lh21");
`endif
    do_st(0, 2'b10, 32'h400, 32'hFFFF_FFFF, 1'b1, "t5_sw400");
    do_ld(0, 2'b10, 1'b0, 32'h0, 32'h0102_0304, 1'b0, "t5_lw0");
    do_ld(0, 2'b10, 1'b0, 32'h3FC, 32'hCAFE_F00D, 1'b0, "t5_lw3fc");
    do_ld(0, 2'b11, 1'b0, 32'h20, 32'h0000_0000, 1'b1, "t5_size11");

    // Random sized traffic against the byte-array model.
    for (int k = 0; k < 4; k++) begin
      if (k == 1) continue;
      for (int i = 0; i < 16; i++) begin
        v = $urandom;
        a = 32'h100 + 32'(4 * i);
        model_xact(k, 1'b1, 2'b10, 1'b0, a, v, erd, eer);
        xact(k, 1'b1, 2'b10, 1'b0, a, v, rd, er);
        check("rnd_fill_err", 32'(er), 32'(eer));
      end
      for (int i = 0; i < 40; i++) begin
        we  = 1'($urandom_range(0, 1));
        sz  = 2'($urandom_range(0, 3));
        uns = 1'($urandom_range(0, 1));
        v   = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 15));
        else                           a = 32'h100 + 32'($urandom_range(0, 63));
        model_xact(k, we, sz, uns, a, v, erd, eer);
        xact(k, we, sz, uns, a, v, rd, er);
        check("rnd_rdata", rd, erd);
        check("rnd_err", 32'(er), 32'(eer));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
